// File: rtl/pool_window_feeder_pkg.sv
// pool_window_feeder_pkg
// Shared definitions for the pooling window feeder and the pooling engine.
// Holds the FSM state encoding, the default bus widths, the widths of the
// image/kernel/stride command fields and helpers derived from them.
package pool_window_feeder_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;
  localparam int IMG_W      = 8;   // img_w / img_h field width
  localparam int KSZ_W      = 4;   // kernel / stride field width
  localparam int CNT_W      = 9;   // window counters: wide enough for ox+stride+K

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    PUSH = 2'd2,
    DONE = 2'd3
  } state_t;

  // Elements per window; the pooling engine uses this as its kernel_size.
  function automatic logic [2*KSZ_W-1:0] kernel_size(input logic [KSZ_W-1:0] k);
    return {{KSZ_W{1'b0}}, k} * {{KSZ_W{1'b0}}, k};
  endfunction

  // A job that cannot produce even one full window is rejected.
  function automatic logic cfg_invalid(input logic [IMG_W-1:0] w,
                                       input logic [IMG_W-1:0] h,
                                       input logic [KSZ_W-1:0] k,
                                       input logic [KSZ_W-1:0] s);
    logic [IMG_W-1:0] k_ext;
    k_ext = {{(IMG_W-KSZ_W){1'b0}}, k};
    return (k == '0) || (s == '0) || (k_ext > w) || (k_ext > h);
  endfunction

endpackage

// File: rtl/pool_window_feeder_addr_gen.sv
// pool_addr_gen
// Window walker for the pooling feeder. Owns the element counters kx/ky
// (position inside the window) and ox/oy (window origin), advances them one
// element per step and forms the memory word address of the current element.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   clear                zero all counters (job accepted)
//   step                 advance to the next element (element written)
//   img_w, img_h         latched map size
//   kernel, stride       latched K and window step
//   base_addr            latched address of element (0,0)
//   addr                 base + (oy+ky)*img_w + (ox+kx), modulo 2^ADDR_W
//   last_in_window       current element is the last one of its window
//   last_in_job          current element is the last one of the whole map
module pool_addr_gen
  import pool_window_feeder_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              step,
  input  logic [IMG_W-1:0]  img_w,
  input  logic [IMG_W-1:0]  img_h,
  input  logic [KSZ_W-1:0]  kernel,
  input  logic [KSZ_W-1:0]  stride,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [ADDR_W-1:0] addr,
  output logic              last_in_window,
  output logic              last_in_job
);

  logic [CNT_W-1:0] kx_q, ky_q, ox_q, oy_q;
  logic [CNT_W-1:0] kx_d, ky_d, ox_d, oy_d;
  logic [CNT_W-1:0] k9, s9, w9, h9, km1;
  logic [CNT_W-1:0] row, col;
  logic             last_kx, last_ky, last_col, last_row;

  assign k9  = {{(CNT_W-KSZ_W){1'b0}}, kernel};
  assign s9  = {{(CNT_W-KSZ_W){1'b0}}, stride};
  assign w9  = {{(CNT_W-IMG_W){1'b0}}, img_w};
  assign h9  = {{(CNT_W-IMG_W){1'b0}}, img_h};
  assign km1 = k9 - 1'b1;

  assign last_kx  = (kx_q == km1);
  assign last_ky  = (ky_q == km1);
  // The next window origin would leave the map: no partial edge windows.
  assign last_col = (ox_q + s9 + k9) > w9;
  assign last_row = (oy_q + s9 + k9) > h9;

  assign last_in_window = last_kx && last_ky;
  assign last_in_job    = last_in_window && last_col && last_row;

  always_comb begin
    kx_d = kx_q;
    ky_d = ky_q;
    ox_d = ox_q;
    oy_d = oy_q;
    if (clear) begin
      kx_d = '0;
      ky_d = '0;
      ox_d = '0;
      oy_d = '0;
    end else if (step) begin
      if (!last_kx) begin
        kx_d = kx_q + 1'b1;
      end else begin
        kx_d = '0;
        if (!last_ky) begin
          ky_d = ky_q + 1'b1;
        end else begin
          ky_d = '0;
          if (!last_col) begin
            ox_d = ox_q + s9;
          end else begin
            ox_d = '0;
            oy_d = oy_q + s9;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kx_q <= '0;
      ky_q <= '0;
      ox_q <= '0;
      oy_q <= '0;
    end else begin
      kx_q <= kx_d;
      ky_q <= ky_d;
      ox_q <= ox_d;
      oy_q <= oy_d;
    end
  end

  assign row = oy_q + ky_q;
  assign col = ox_q + kx_q;
  // Everything is evaluated at ADDR_W so the result wraps modulo 2^ADDR_W.
  assign addr = base_addr + ADDR_W'(row) * ADDR_W'(img_w) + ADDR_W'(col);

endmodule

// File: rtl/pool_window_feeder.sv
// pool_window_feeder
// Walks a 2-D feature map in on-chip memory, reads each K x K pooling window
// element by element and pushes the elements into the pooling engine's FIFO.
// One job at a time is accepted over a valid/ready command handshake.
// Optional feature macro: POOL_FEEDER_STALL_CNT_EN adds the stall_cnt output,
// a saturating count of PUSH cycles spent waiting on a full FIFO.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   cmd_valid / cmd_ready         job handshake (ready only in IDLE)
//   img_w, img_h, kernel, stride  job geometry, sampled on acceptance
//   base_addr                     word address of element (0,0)
//   mem_req/mem_addr/mem_ack/mem_rd_data  single-outstanding read port
//   fifo_full, fifo_wr_en, fifo_wr_data   consumer FIFO write side
//   win_last                      marks the last element of a window
//   done, err                     end-of-job pulse; err marks a rejected job
//   stall_cnt                     (macro only) FIFO-full stall cycles
module pool_window_feeder
  import pool_window_feeder_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [IMG_W-1:0]  img_w,
  input  logic [IMG_W-1:0]  img_h,
  input  logic [KSZ_W-1:0]  kernel,
  input  logic [KSZ_W-1:0]  stride,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              fifo_full,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wr_data,
  output logic              win_last,
  output logic              done,
  output logic              err
`ifdef POOL_FEEDER_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  state_t            state_q, state_d;
  logic [IMG_W-1:0]  img_w_q, img_h_q;
  logic [KSZ_W-1:0]  kernel_q, stride_q;
  logic [ADDR_W-1:0] base_q;
  logic [DATA_W-1:0] data_q;
  logic              err_q;

  logic              accept, bad_cmd, clear, step, capture;
  logic [ADDR_W-1:0] gen_addr;
  logic              last_in_window, last_in_job;

  assign accept  = (state_q == IDLE) && cmd_valid;
  assign bad_cmd = cfg_invalid(img_w, img_h, kernel, stride);
  assign capture = (state_q == REQ) && mem_ack;

  pool_addr_gen #(
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clk           (clk),
    .rst           (rst),
    .clear         (clear),
    .step          (step),
    .img_w         (img_w_q),
    .img_h         (img_h_q),
    .kernel        (kernel_q),
    .stride        (stride_q),
    .base_addr     (base_q),
    .addr          (gen_addr),
    .last_in_window(last_in_window),
    .last_in_job   (last_in_job)
  );

  always_comb begin
    state_d    = state_q;
    cmd_ready  = 1'b0;
    mem_req    = 1'b0;
    fifo_wr_en = 1'b0;
    done       = 1'b0;
    clear      = 1'b0;
    step       = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          clear   = 1'b1;
          state_d = bad_cmd ? DONE : REQ;
        end
      end
      REQ: begin
        mem_req = 1'b1;
        if (mem_ack) state_d = PUSH;
      end
      PUSH: begin
        // A full FIFO simply parks the FSM here with data and counters intact.
        if (!fifo_full) begin
          fifo_wr_en = 1'b1;
          step       = 1'b1;
          state_d    = last_in_job ? DONE : REQ;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      img_w_q  <= '0;
      img_h_q  <= '0;
      kernel_q <= '0;
      stride_q <= '0;
      base_q   <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        img_w_q  <= img_w;
        img_h_q  <= img_h;
        kernel_q <= kernel;
        stride_q <= stride;
        base_q   <= base_addr;
        err_q    <= bad_cmd;
      end
      if (capture) data_q <= mem_rd_data;
    end
  end

  // Address is forced to zero outside REQ so the bus is quiet when idle.
  assign mem_addr     = mem_req ? gen_addr : '0;
  assign fifo_wr_data = data_q;
  assign win_last     = fifo_wr_en && last_in_window;
  assign err          = done && err_q;

`ifdef POOL_FEEDER_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (accept) begin
      stall_q <= '0;
    end else if ((state_q == PUSH) && fifo_full && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_pool_window_feeder.sv
// tb_pool_window_feeder
// Self-checking bench for pool_window_feeder: table of jobs run through a
// memory model that answers with data = address, a scoreboard of expected
// FIFO writes built from a window-walk model, and hand-written sequences for
// FIFO stall, delayed ack and mid-job reset.
module tb_pool_window_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  img_w, img_h;
  logic [3:0]  kernel, stride;
  logic [15:0] base_addr;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rd_data;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [15:0] fifo_wr_data;
  logic        win_last;
  logic        done;
  logic        err;
`ifdef POOL_FEEDER_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  pool_window_feeder #(
    .DATA_W(16),
    .ADDR_W(16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .img_w       (img_w),
    .img_h       (img_h),
    .kernel      (kernel),
    .stride      (stride),
    .base_addr   (base_addr),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rd_data (mem_rd_data),
    .fifo_full   (fifo_full),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_wr_data(fifo_wr_data),
    .win_last    (win_last),
    .done        (done),
    .err         (err)
`ifdef POOL_FEEDER_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  typedef struct {
    logic [15:0] data;
    logic        last;
  } exp_t;

  typedef struct {
    int w, h, k, s, base;
    bit e;
    int nw;
  } job_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          ack_dly = 0;
  bit          spur_en = 1'b0;
  bit          exp_err_g = 1'b0;
  bit          saw_req = 1'b0;
  int          wr_count = 0;
  int          last_wr_cyc = -10;
  int          done_cnt = 0;
  int          req_cycles = 0;
  bit          prev_req = 1'b0;
  logic [15:0] prev_addr = '0;
  logic [15:0] log_data [64];
  logic        log_last [64];

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory: acknowledges after ack_dly extra REQ cycles, data = address.
  initial begin
    int req_cnt;
    req_cnt     = 0;
    mem_ack     = 1'b0;
    mem_rd_data = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req) begin
        if (req_cnt >= ack_dly) begin
          mem_ack     = 1'b1;
          mem_rd_data = mem_addr;
          req_cnt     = 0;
        end else begin
          mem_ack     = 1'b0;
          mem_rd_data = 16'hBEEF;
          req_cnt++;
        end
      end else begin
        mem_ack     = spur_en;
        mem_rd_data = spur_en ? 16'hDEAD : 16'hBEEF;
        req_cnt     = 0;
      end
    end
  end

  // Output monitor and scoreboard.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      prev_req   = 1'b0;
      req_cycles = 0;
    end else begin
      if (mem_req) begin
        saw_req = 1'b1;
        if (prev_req) chk(mem_addr == prev_addr, "mem_addr_stable", int'(mem_addr), int'(prev_addr));
        req_cycles++;
      end
      prev_req  = mem_req;
      prev_addr = mem_addr;
      if (fifo_wr_en) begin
        if (sb.size() == 0) begin
          chk(1'b0, "unexpected_write", int'(fifo_wr_data), 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk(fifo_wr_data == e.data, "wr_data", int'(fifo_wr_data), int'(e.data));
          chk(win_last == e.last, "win_last", int'(win_last), int'(e.last));
        end
        chk(req_cycles == ack_dly + 1, "req_cycles_per_elem", req_cycles, ack_dly + 1);
        req_cycles = 0;
        if (wr_count < 64) begin
          log_data[wr_count] = fifo_wr_data;
          log_last[wr_count] = win_last;
        end
        wr_count++;
        last_wr_cyc = cyc;
      end else if (win_last) begin
        chk(1'b0, "win_last_without_write", 1, 0);
      end
      if (done) begin
        done_cnt++;
        if (!exp_err_g) chk(cyc == last_wr_cyc + 1, "done_after_last_write", cyc - last_wr_cyc, 1);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic start_job(input job_t j);
    sb.delete();
    if (!j.e) begin
      for (int oy = 0; oy + j.k <= j.h; oy += j.s)
        for (int ox = 0; ox + j.k <= j.w; ox += j.s)
          for (int ky = 0; ky < j.k; ky++)
            for (int kx = 0; kx < j.k; kx++) begin
              exp_t e;
              e.data = 16'(j.base + (oy + ky) * j.w + ox + kx);
              e.last = (kx == j.k - 1) && (ky == j.k - 1);
              sb.push_back(e);
            end
    end
    exp_err_g = j.e;
    wr_count  = 0;
    saw_req   = 1'b0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    img_w     = 8'(j.w);
    img_h     = 8'(j.h);
    kernel    = 4'(j.k);
    stride    = 4'(j.s);
    base_addr = 16'(j.base);
    @(posedge clk);
    #1;
    // Command inputs are free to change once the job is accepted.
    cmd_valid = 1'b0;
    img_w     = 8'($urandom);
    img_h     = 8'($urandom);
    kernel    = 4'($urandom);
    stride    = 4'($urandom);
    base_addr = 16'($urandom);
  endtask

  task automatic wait_done(input int nw);
    int n;
    n = 0;
    @(negedge clk);
    chk(cmd_ready == 1'b0, "busy_not_ready", int'(cmd_ready), 0);
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(done == 1'b1, "done_seen", int'(done), 1);
    chk(err == 1'b0, "err_clear", int'(err), 0);
    chk(wr_count == nw, "write_count", wr_count, nw);
    chk(sb.size() == 0, "scoreboard_empty", sb.size(), 0);
    @(negedge clk);
    chk(cmd_ready == 1'b1 && done == 1'b0, "ready_after_done", int'({cmd_ready, done}), 2);
  endtask

  task automatic run_job(input job_t j);
    start_job(j);
    if (j.e) begin
      @(negedge clk);
      chk(done == 1'b1, "err_job_done_T1", int'(done), 1);
      chk(err == 1'b1, "err_job_err_T1", int'(err), 1);
      @(negedge clk);
      chk(cmd_ready == 1'b1, "err_job_ready_T2", int'(cmd_ready), 1);
      chk(done == 1'b0, "err_job_done_single", int'(done), 0);
      chk(saw_req == 1'b0, "err_job_no_mem_req", int'(saw_req), 0);
    end else begin
      wait_done(j.nw);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk(cmd_ready == 1'b1, {tag, "_cmd_ready"}, int'(cmd_ready), 1);
    chk(mem_req == 1'b0, {tag, "_mem_req"}, int'(mem_req), 0);
    chk(mem_addr == 16'h0, {tag, "_mem_addr"}, int'(mem_addr), 0);
    chk(fifo_wr_en == 1'b0, {tag, "_fifo_wr_en"}, int'(fifo_wr_en), 0);
    chk(fifo_wr_data == 16'h0, {tag, "_fifo_wr_data"}, int'(fifo_wr_data), 0);
    chk(win_last == 1'b0, {tag, "_win_last"}, int'(win_last), 0);
    chk(done == 1'b0, {tag, "_done"}, int'(done), 0);
    chk(err == 1'b0, {tag, "_err"}, int'(err), 0);
`ifdef POOL_FEEDER_STALL_CNT_EN
    chk(stall_cnt == 16'h0, {tag, "_stall_cnt"}, int'(stall_cnt), 0);
`endif
  endtask

  task automatic check_log(input string tag, input logic [15:0] exp_d [16]);
    for (int i = 0; i < 16; i++) begin
      chk(log_data[i] == exp_d[i], {tag, "_data"}, int'(log_data[i]), int'(exp_d[i]));
      chk(log_last[i] == (i % 4 == 3), {tag, "_last"}, int'(log_last[i]), int'(i % 4 == 3));
    end
  endtask

  job_t        jobs [10];
  logic [15:0] exp44 [16];
  logic [15:0] exp33 [16];

  initial begin
    job_t j;
    int   n;
    int   done_snap;
    logic [15:0] held;

    rst = 1'b1;
    cmd_valid = 1'b0;
    img_w = '0; img_h = '0; kernel = '0; stride = '0; base_addr = '0;
    fifo_full = 1'b0;

    jobs[0] = '{w:4, h:4, k:2, s:2, base:'h100,  e:1'b0, nw:16};
    jobs[1] = '{w:3, h:3, k:2, s:1, base:0,      e:1'b0, nw:16};
    jobs[2] = '{w:4, h:4, k:5, s:1, base:0,      e:1'b1, nw:0};
    jobs[3] = '{w:4, h:4, k:0, s:1, base:0,      e:1'b1, nw:0};
    jobs[4] = '{w:4, h:4, k:2, s:0, base:0,      e:1'b1, nw:0};
    jobs[5] = '{w:5, h:7, k:3, s:2, base:'h0FF0, e:1'b0, nw:54};
    jobs[6] = '{w:6, h:5, k:2, s:3, base:'hFFF0, e:1'b0, nw:16};
    jobs[7] = '{w:4, h:4, k:4, s:1, base:'h20,   e:1'b0, nw:16};
    jobs[8] = '{w:1, h:1, k:1, s:1, base:'h5,    e:1'b0, nw:1};
    jobs[9] = '{w:8, h:3, k:4, s:1, base:'h40,   e:1'b1, nw:0};
    exp44 = '{16'h100, 16'h101, 16'h104, 16'h105, 16'h102, 16'h103, 16'h106, 16'h107,
              16'h108, 16'h109, 16'h10C, 16'h10D, 16'h10A, 16'h10B, 16'h10E, 16'h10F};
    exp33 = '{16'h0, 16'h1, 16'h3, 16'h4, 16'h1, 16'h2, 16'h4, 16'h5,
              16'h3, 16'h4, 16'h6, 16'h7, 16'h4, 16'h5, 16'h7, 16'h8};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_job(jobs[i]);
      if (i == 0) check_log("map4x4", exp44);
      if (i == 1) check_log("map3x3", exp33);
`ifdef POOL_FEEDER_STALL_CNT_EN
      chk(stall_cnt == 16'h0, "stall_cnt_no_stall", int'(stall_cnt), 0);
`endif
    end

    // FIFO full for 5 cycles in the first PUSH, spurious acks outside REQ.
    spur_en = 1'b1;
    j = '{w:4, h:4, k:2, s:2, base:'h100, e:1'b0, nw:16};
    start_job(j);
    held = sb[0].data;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(mem_req && mem_ack) && n < 100);
    chk(mem_req && mem_ack, "stall_first_ack", int'(mem_ack), 1);
    @(posedge clk);
    #1;
    fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk(fifo_wr_en == 1'b0, "stall_no_write", int'(fifo_wr_en), 0);
      chk(fifo_wr_data == held, "stall_data_hold", int'(fifo_wr_data), int'(held));
    end
    @(posedge clk);
    #1;
    fifo_full = 1'b0;
    @(negedge clk);
    chk(fifo_wr_en == 1'b1, "stall_release_write", int'(fifo_wr_en), 1);
    wait_done(16);
    check_log("map4x4_stall", exp44);
`ifdef POOL_FEEDER_STALL_CNT_EN
    chk(stall_cnt == 16'd5, "stall_cnt_five", int'(stall_cnt), 5);
`endif
    spur_en = 1'b0;

    // Ack delayed by 3 cycles: request and address must hold for 4 cycles.
    ack_dly = 3;
    j = '{w:2, h:2, k:2, s:1, base:'h3A0, e:1'b0, nw:4};
    run_job(j);
    ack_dly = 0;

    // Reset in the middle of a job, after the sixth write.
    j = '{w:4, h:4, k:2, s:2, base:'h100, e:1'b0, nw:16};
    start_job(j);
    n = 0;
    while (wr_count < 6 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(wr_count == 6, "midjob_six_writes", wr_count, 6);
    done_snap = done_cnt;
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("async_reset");
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk(done_cnt == done_snap, "no_done_on_abort", done_cnt, done_snap);
    run_job(j);
    check_log("map4x4_after_reset", exp44);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pool_window_feeder.md
# pool_window_feeder

Writer-side companion to the max-pooling compare engine. It walks a 2-D feature map in on-chip memory, fetches each K×K pooling window element by element, and pushes the elements into the FIFO the pooling engine drains. It marks the last element of every window and signals completion of the whole map. One job is accepted at a time via a valid/ready command handshake.

## Interface
Parameters:
- DATA_W, 16, element width (fp16 payload, passed through untouched)
- ADDR_W, 16, memory word-address width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  job request
- cmd_ready  out  1  high only in IDLE
- img_w  in  8  map width in elements
- img_h  in  8  map height in elements
- kernel  in  4  square kernel side K
- stride  in  4  window step, both axes
- base_addr  in  ADDR_W  word address of element (0,0)
- mem_req  out  1  read request, held until ack
- mem_addr  out  ADDR_W  read address, stable while mem_req
- mem_ack  in  1  read done; mem_rd_data valid this cycle
- mem_rd_data  in  DATA_W  read data
- fifo_full  in  1  consumer FIFO full
- fifo_wr_en  out  1  FIFO write strobe
- fifo_wr_data  out  DATA_W  FIFO write data
- win_last  out  1  qualifies last element of a window
- done  out  1  one-cycle pulse, job finished
- err  out  1  qualifies done: job rejected, no data

## Operation
- States: IDLE, REQ, PUSH, DONE.
- IDLE: cmd_ready=1. On cmd_valid: latch img_w, img_h, kernel, stride, base_addr; clear counters kx, ky, ox, oy. If K==0, stride==0, K>img_w or K>img_h, go to DONE with err; otherwise go to REQ.
- REQ: mem_req=1, mem_addr = base + (oy+ky)*img_w + (ox+kx), truncated modulo 2^ADDR_W. On mem_ack, capture mem_rd_data into fifo_wr_data and go to PUSH.
- PUSH: fifo_wr_en = !fifo_full (combinational). On the write, advance the counters:
  - kx steps fastest, then ky, then ox by stride, then oy by stride.
  - A window column is valid while ox+K ≤ img_w; a window row is valid while oy+K ≤ img_h.
  - Counters use 9-bit arithmetic so there is no overflow.
  - After the write, go to REQ, or to DONE after the last element of the last window.
- DONE: done=1 for one cycle, then IDLE.
- win_last = fifo_wr_en && kx==K-1 && ky==K-1.
- Window element count equals K*K. This is the consumer's kernel_size.
- Window count is ((img_w−K)/stride+1)·((img_h−K)/stride+1), floor division.
- Boundary rules:
  - mem_ack outside REQ is ignored.
  - fifo_full while in PUSH holds state, data and counters indefinitely.
  - Partial edge windows are never emitted.
  - Command inputs may change once accepted.

## Timing
- Reset values: state IDLE, so cmd_ready=1. mem_req, fifo_wr_en, win_last, done and err are 0. mem_addr and fifo_wr_data are 0. All counters are 0.
- Accept at cycle T. mem_req is high at T+1 at the earliest; err jobs instead pulse done/err at T+1.
- mem_ack at cycle A: mem_req drops at A+1, and fifo_wr_en is high at A+1 if !fifo_full.
- Peak throughput is one element per 2 cycles (ack in the first REQ cycle, no full).
- done pulses the cycle after the final write. cmd_ready returns the cycle after done.
- Reset mid-job aborts immediately: no done pulse, and in-flight read data is discarded. Memory must tolerate a dropped request.

## Configuration
- POOL_FEEDER_STALL_CNT_EN defined:
  - Adds output port stall_cnt (out, 16 bits).
  - It counts cycles in PUSH with fifo_full=1 and saturates at 0xFFFF.
  - It clears on command acceptance and on reset.
  - It holds its value after done.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Shared package holds:
  - the state encoding typedef (IDLE/REQ/PUSH/DONE)
  - DATA_W/ADDR_W defaults
  - widths for the K/stride/image fields, shared with the pooling engine's kernel_size derivation
- One sub-module, pool_addr_gen:
  - owns kx/ky/ox/oy, the step logic and the address computation
  - emits last_in_window and last_in_job
- The top module keeps the FSM, the handshakes and the stall counter.

## Test plan
- 4×4 map, K=2, stride=2, base 0x100, memory returns data=address, immediate ack:
  - 16 writes with data 100,101,104,105, 102,103,106,107, 108,109,10C,10D, 10A,10B,10E,10F
  - win_last on writes 4/8/12/16
  - done one cycle after write 16
- 3×3 map, K=2, stride=1, base 0:
  - 4 windows, 16 writes
  - first window 0,1,3,4; last window 4,5,7,8
  - err=0
- fifo_full held high for 5 cycles in PUSH:
  - no fifo_wr_en and fifo_wr_data unchanged during the stall
  - the write occurs on the first cycle full=0
  - stall_cnt=5 when the macro is defined
- mem_ack delayed 3 cycles: mem_req and mem_addr are stable for all 4 REQ cycles, and exactly one write follows.
- K=5 on a 4×4 map: done=1 and err=1 at T+1, mem_req never asserts, cmd_ready=1 at T+2. K=0 and stride=0 behave the same way.
- rst asserted mid-job after write 6:
  - all outputs return to reset values asynchronously
  - no done pulse
  - a new 4×4, K=2, stride=2 job runs cleanly from address base
